load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - CPU-side initiator for the word-wide data memory: converts byte/half/word load and store
//   requests from the pipeline MEM stage into that memory's write/read port signals.
// - Memory contract: word-only writes; registered read data one clock after mem_re.
// - Handles load lane extraction and sign/zero extension.
// - Sub-word stores are implemented as read-modify-write.
// - One request outstanding; the pipeline stalls on req_ready=0.
// PARAMETERS
// - A_WIDTH      32  request/memory address width
// - MEM_A_WIDTH  8   log2 of memory depth in words; used for range check
// PORTS
// - clk           in   1        rising-edge clock
// - rst_n         in   1        synchronous, active-low reset
// - req_valid     in   1        request present
// - req_ready     out  1        unit idle, request accepted when valid&ready at clk edge
// - req_we        in   1        1=store, 0=load
// - req_size      in   2        0=byte, 1=half, 2=word, 3=reserved
// - req_unsigned  in   1        loads: 1=zero-extend, 0=sign-extend
// - req_addr      in   A_WIDTH  byte address
// - req_wdata     in   32       store data, low bits significant for byte/half
// - resp_valid    out  1        one-cycle completion pulse (loads and stores)
// - resp_rdata    out  32       extended load data; 0 for stores and errors
// - resp_err      out  1        misaligned/out-of-range/reserved size (see CONFIGURATION)
// - mem_we        out  1        memory write enable
// - mem_w_addr    out  A_WIDTH  word-aligned write address ([1:0]=0)
// - mem_w_data    out  32       memory write data
// - mem_re        out  1        memory read enable
// - mem_r_addr    out  A_WIDTH  word-aligned read address ([1:0]=0)
// - mem_r_data    in   32       memory read data, valid the cycle after mem_re
// BEHAVIOUR
// - Reset: rst_n low at an edge -> state IDLE.
//   - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_re=0.
//   - Any in-flight RMW is aborted with no memory write; no response is issued for it.
// - Request capture: addr, size, we, unsigned and wdata are registered at acceptance edge k.
//   Inputs are ignored while busy.
// - States:
//   - IDLE: req_ready=1. Transitions on acceptance:
//     - error  -> RESP
//     - load   -> LD_RD
//     - word store -> ST_WR
//     - byte/half store -> RMW_RD
//   - LD_RD: mem_re=1, mem_r_addr={addr[A-1:2],2'b00} -> LD_DATA.
//   - LD_DATA: select lane from mem_r_data by addr[1:0] (little-endian), extend into resp_rdata -> RESP.
//   - ST_WR: mem_we=1, mem_w_data=wdata -> RESP.
//   - RMW_RD: mem_re=1 at the word address -> RMW_WR.
//   - RMW_WR: mem_we=1; mem_w_data = mem_r_data with the addressed byte/half lane replaced
//     by wdata[7:0]/[15:0] (combinational merge) -> RESP.
//   - RESP: resp_valid=1 for exactly one cycle; req_ready=1; returns to IDLE.
//     - Back-to-back: a new request may be accepted at the edge leaving RESP.
// - Latency, with acceptance at edge k: the resp_valid cycle begins at the edge shown.
//   - error: edge k+1
//   - word store: edge k+2
//   - load: edge k+3
//   - sub-word store: edge k+3
// - mem_we and mem_re are never both 1 in the same cycle.
// - Memory-side outputs other than enables are don't-care when their enable is 0.
// - Half lanes: addr[1]=0 -> [15:0], 1 -> [31:16]. Byte lanes: addr[1:0] selects [8n+7:8n].
// CONFIGURATION
// - LSU_ERR_EN defined, an error is any of:
//   - half with addr[0]=1
//   - word with addr[1:0]!=0
//   - req_size=3
//   - addr[A_WIDTH-1:MEM_A_WIDTH+2]!=0
//   On error: no memory access; resp_err=1; resp_rdata=0.
// - LSU_ERR_EN undefined:
//   - resp_err is tied 0.
//   - Misaligned half/word use the aligned lane (addr[0] ignored for half, addr[1:0] for word).
//   - req_size=3 is treated as word.
//   - Upper address bits pass through unchecked.
// TESTING
// - Reset: rst_n=0 two edges mid-RMW -> after release req_ready=1, no mem_we seen, no resp.
// - Word store then load:
//   - store 0xDEADBEEF at 0x10 -> mem_we at k+1, addr 0x10.
//   - load 0x10 -> resp_rdata=0xDEADBEEF at k+3.
// - Byte store RMW: mem[0x10]=0xDEADBEEF; store byte 0x55 at 0x12 -> mem_w_data=0xDE55BEEF.
// - Load extension: mem[0x20]=0x0000F080.
//   - signed byte at 0x20 -> 0xFFFFFF80
//   - unsigned half at 0x20 -> 0x0000F080
//   - signed half at 0x22 -> 0x00000000
// - Back-to-back: req_valid held with 3 loads -> responses at 3-edge spacing; req_ready low when busy.
// - Errors with LSU_ERR_EN: word load at 0x13 and load at 0x400 -> resp_err=1 at k+1, no mem_re;
//   without the macro, word load at 0x13 returns mem[0x10].

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles for load_store_unit: pipeline request/response side
// and the word-wide data memory port side.
interface load_store_unit_if #(
   parameter int A_WIDTH = 32
);
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [1:0]         req_size;
   logic               req_unsigned;
   logic [A_WIDTH-1:0] req_addr;
   logic [31:0]        req_wdata;
   logic               resp_valid;
   logic [31:0]        resp_rdata;
   logic               resp_err;

   modport master (
      output req_valid, req_we, req_size,
      output req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid,
      input  resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size,
      input  req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid,
      output resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(
   parameter int A_WIDTH = 32
);
   logic               mem_we;
   logic [A_WIDTH-1:0] mem_w_addr;
   logic [31:0]        mem_w_data;
   logic               mem_re;
   logic [A_WIDTH-1:0] mem_r_addr;
   logic [31:0]        mem_r_data;

   modport master (
      output mem_we, mem_w_addr, mem_w_data,
      output mem_re, mem_r_addr,
      input  mem_r_data
   );

   modport slave (
      input  mem_we, mem_w_addr, mem_w_data,
      input  mem_re, mem_r_addr,
      output mem_r_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a word-only data memory.
// Define LSU_ERR_EN to flag misaligned, reserved-size and out-of-range requests.
module load_store_unit #(
   parameter int A_WIDTH     = 32,
   parameter int MEM_A_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave req,
   lsu_mem_if.master        mem
);

   typedef enum logic [2:0] {
      IDLE,
      LD_RD,
      LD_DATA,
      ST_WR,
      RMW_RD,
      RMW_WR,
      RESP
   } state_t;

   state_t state, state_nx;

   logic [A_WIDTH-1:0] addr_q;
   logic [1:0]         size_q;
   logic               unsigned_q;
   logic [31:0]        wdata_q;
   logic               err_q;
   logic [31:0]        rdata_q;

   logic               idle;
   logic               accept;
   logic               err;

   logic [4:0]         bsh;
   logic [4:0]         hsh;
   logic [7:0]         lb;
   logic [15:0]        lh;
   logic [31:0]        ext;
   logic [31:0]        mask;
   logic [31:0]        ins;
   logic [31:0]        merged;

   assign idle   = (state == IDLE) || (state == RESP);
   assign accept = idle && req.req_valid;

`ifdef LSU_ERR_EN
   logic addr_hi;

   if (MEM_A_WIDTH + 2 < A_WIDTH) begin : g_hi
      assign addr_hi =
         |req.req_addr[A_WIDTH-1:MEM_A_WIDTH+2];
   end else begin : g_no_hi
      assign addr_hi = 1'b0;
   end

   assign err =
      (req.req_size == 2'd3) ||
      ((req.req_size == 2'd1) && req.req_addr[0]) ||
      ((req.req_size == 2'd2) && (req.req_addr[1:0] != 2'b00)) ||
      addr_hi;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         size_q     <= 2'd0;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q     <= req.req_addr;
            size_q     <= req.req_size;
            unsigned_q <= req.req_unsigned;
            wdata_q    <= req.req_wdata;
            err_q      <= err;
            rdata_q    <= '0;
         end else if (state == LD_DATA) begin
            rdata_q <= ext;
         end
      end
   end

   // Lane select for loads and lane merge for read-modify-write.
   always_comb begin
      bsh  = {addr_q[1:0], 3'b000};
      hsh  = {addr_q[1], 4'b0000};
      lb   = 8'(mem.mem_r_data >> bsh);
      lh   = 16'(mem.mem_r_data >> hsh);
      ext  = mem.mem_r_data;
      mask = '1;
      ins  = wdata_q;
      unique case (size_q)
         2'd0: begin
            ext  = {{24{lb[7] & ~unsigned_q}}, lb};
            mask = 32'h0000_00ff << bsh;
            ins  = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            ext  = {{16{lh[15] & ~unsigned_q}}, lh};
            mask = 32'h0000_ffff << hsh;
            ins  = {2{wdata_q[15:0]}};
         end
         default: begin
            ext  = mem.mem_r_data;
            mask = '1;
            ins  = wdata_q;
         end
      endcase
      merged = (mem.mem_r_data & ~mask) | (ins & mask);
   end

   always_comb begin
      state_nx       = state;
      mem.mem_we     = 1'b0;
      mem.mem_re     = 1'b0;
      mem.mem_w_data = wdata_q;
      unique case (state)
         IDLE, RESP: begin
            state_nx = IDLE;
            if (accept) begin
               unique case (1'b1)
                  err:
                     state_nx = RESP;
                  !err && !req.req_we:
                     state_nx = LD_RD;
                  !err && req.req_we && req.req_size[1]:
                     state_nx = ST_WR;
                  !err && req.req_we && !req.req_size[1]:
                     state_nx = RMW_RD;
                  default:
                     state_nx = IDLE;
               endcase
            end
         end
         LD_RD: begin
            mem.mem_re = 1'b1;
            state_nx   = LD_DATA;
         end
         LD_DATA: begin
            state_nx = RESP;
         end
         ST_WR: begin
            mem.mem_we = 1'b1;
            state_nx   = RESP;
         end
         RMW_RD: begin
            mem.mem_re = 1'b1;
            state_nx   = RMW_WR;
         end
         RMW_WR: begin
            mem.mem_we     = 1'b1;
            mem.mem_w_data = merged;
            state_nx       = RESP;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign mem.mem_w_addr  = {addr_q[A_WIDTH-1:2], 2'b00};
   assign mem.mem_r_addr  = {addr_q[A_WIDTH-1:2], 2'b00};

   assign req.req_ready  = idle;
   assign req.resp_valid = (state == RESP);
   assign req.resp_rdata = rdata_q;
   assign req.resp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset and
// back-to-back sequences, then random traffic against a byte model.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   load_store_unit_if #(.A_WIDTH(32)) rq();
   lsu_mem_if #(.A_WIDTH(32)) mb();

   load_store_unit #(
      .A_WIDTH(32),
      .MEM_A_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(rq),
      .mem(mb)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] init_word(int i);
      case (i)
         0: return 32'h0BAD_F00D;
         4: return 32'h0000_0000;
         8: return 32'h0000_F080;
         default: return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
      endcase
   endfunction

   // Word-wide memory with a registered read port.
   logic [31:0] mem_arr [256];
   logic [31:0] mem_rd = '0;
   logic        mem_ok = 1'b0;

   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
         mem_ok <= 1'b1;
      end else if (mb.mem_we) begin
         mem_arr[mb.mem_w_addr[9:2]] <= mb.mem_w_data;
      end
      if (mb.mem_re) mem_rd <= mem_arr[mb.mem_r_addr[9:2]];
   end

   assign mb.mem_r_data = mem_rd;

   int we_cnt = 0;
   int re_cnt = 0;
   int both_cnt = 0;
   int resp_cnt = 0;
   int acc_cnt = 0;
   int cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mb.mem_we) we_cnt <= we_cnt + 1;
      if (mb.mem_re) re_cnt <= re_cnt + 1;
      if (mb.mem_we && mb.mem_re) both_cnt <= both_cnt + 1;
      if (rq.resp_valid) resp_cnt <= resp_cnt + 1;
      if (rq.req_valid && rq.req_ready) acc_cnt <= acc_cnt + 1;
   end

   // Reference: byte-addressed memory, little-endian.
   logic [7:0] ref_b [1024];

   function automatic void model(
      input  logic        we,
      input  logic [1:0]  sz,
      input  logic        uns,
      input  logic [31:0] addr,
      input  logic [31:0] wd,
      output logic [31:0] rd,
      output logic        er,
      output int          lat,
      output int          nre,
      output int          nwe
   );
      int n;
      logic [9:0] a;
      logic [31:0] v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      er = 1'b0;
`ifdef LSU_ERR_EN
      er = (sz == 2'd3) || (addr % n != 0) || (addr >= 32'h400);
`endif
      a = 10'(addr - addr % n);
      rd = '0;
      lat = 1;
      nre = 0;
      nwe = 0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < n; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
         lat = (n == 4) ? 2 : 3;
         nre = (n == 4) ? 0 : 1;
         nwe = 1;
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[int'(a) + i];
         if (!uns && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
         rd = v;
         lat = 3;
         nre = 1;
      end
   endfunction

   task automatic do_req(
      input  logic        we,
      input  logic [1:0]  sz,
      input  logic        uns,
      input  logic [31:0] addr,
      input  logic [31:0] wd,
      output logic [31:0] rd,
      output logic        er,
      output int          lat,
      output int          nre,
      output int          nwe
   );
      int w;
      int re0;
      int we0;
      w = 0;
      while (!rq.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      rq.req_valid = 1'b1;
      rq.req_we = we;
      rq.req_size = sz;
      rq.req_unsigned = uns;
      rq.req_addr = addr;
      rq.req_wdata = wd;
      re0 = re_cnt;
      we0 = we_cnt;
      @(negedge clk);
      rq.req_valid = 1'b0;
      lat = 1;
      while (!rq.resp_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      if (!rq.resp_valid) lat = 99;
      rd = rq.resp_rdata;
      er = rq.resp_err;
      nre = re_cnt - re0;
      nwe = we_cnt - we0;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          nre;
      int          nwe;
   } vec_t;

   vec_t vt [15];

   initial begin
      logic [31:0] w;
      logic [31:0] rd, mrd;
      logic er, mer;
      int lat, nre, nwe, mlat, mnre, mnwe;
      int nrdy, nresp, diffs, we0, resp0, a0;
      int rt [3];
      string nm;

      for (int i = 0; i < 256; i++) begin
         w = init_word(i);
         for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
      end

      vt[0]  = '{1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1};
      vt[1]  = '{0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, 0};
      vt[2]  = '{1, 2'd0, 0, 32'h12, 32'hAAAA_AA55, 32'h0, 0, 3, 1, 1};
      vt[3]  = '{0, 2'd2, 0, 32'h10, 32'h0, 32'hDE55_BEEF, 0, 3, 1, 0};
      vt[4]  = '{0, 2'd0, 0, 32'h20, 32'h0, 32'hFFFF_FF80, 0, 3, 1, 0};
      vt[5]  = '{0, 2'd1, 1, 32'h20, 32'h0, 32'h0000_F080, 0, 3, 1, 0};
      vt[6]  = '{0, 2'd1, 0, 32'h22, 32'h0, 32'h0000_0000, 0, 3, 1, 0};
      vt[7]  = '{0, 2'd0, 1, 32'h21, 32'h0, 32'h0000_00F0, 0, 3, 1, 0};
      vt[8]  = '{0, 2'd0, 0, 32'h21, 32'h0, 32'hFFFF_FFF0, 0, 3, 1, 0};
      vt[9]  = '{1, 2'd1, 0, 32'h22, 32'hA5A5_1234, 32'h0, 0, 3, 1, 1};
      vt[10] = '{0, 2'd2, 0, 32'h20, 32'h0, 32'h1234_F080, 0, 3, 1, 0};
`ifdef LSU_ERR_EN
      vt[11] = '{0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0};
      vt[12] = '{0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0};
      vt[13] = '{0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0};
      vt[14] = '{0, 2'd1, 0, 32'h21, 32'h0, 32'h0, 1, 1, 0, 0};
`else
      vt[11] = '{0, 2'd2, 0, 32'h13, 32'h0, 32'hDE55_BEEF, 0, 3, 1, 0};
      vt[12] = '{0, 2'd2, 0, 32'h400, 32'h0, 32'h0BAD_F00D, 0, 3, 1, 0};
      vt[13] = '{0, 2'd3, 0, 32'h10, 32'h0, 32'hDE55_BEEF, 0, 3, 1, 0};
      vt[14] = '{0, 2'd1, 0, 32'h21, 32'h0, 32'hFFFF_F080, 0, 3, 1, 0};
`endif

      rq.req_valid = 1'b0;
      rq.req_we = 1'b0;
      rq.req_size = 2'd0;
      rq.req_unsigned = 1'b0;
      rq.req_addr = '0;
      rq.req_wdata = '0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(rq.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
      chk("rst_rdata", rq.resp_rdata, 32'd0);
      chk("rst_err", 32'(rq.resp_err), 32'd0);
      chk("rst_mem_we", 32'(mb.mem_we), 32'd0);
      chk("rst_mem_re", 32'(mb.mem_re), 32'd0);

      for (int i = 0; i < 15; i++) begin
         do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
                rd, er, lat, nre, nwe);
         model(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
               mrd, mer, mlat, mnre, mnwe);
         nm = $sformatf("vec%0d", i);
         chk({nm, "_rdata"}, rd, vt[i].rd);
         chk({nm, "_err"}, 32'(er), 32'(vt[i].er));
         chk({nm, "_lat"}, 32'(lat), 32'(vt[i].lat));
         chk({nm, "_nre"}, 32'(nre), 32'(vt[i].nre));
         chk({nm, "_nwe"}, 32'(nwe), 32'(vt[i].nwe));
      end
      chk("rmw_word_10", mem_arr[4], 32'hDE55_BEEF);
      chk("rmw_word_20", mem_arr[8], 32'h1234_F080);

      // Reset asserted while a byte store sits in its read phase.
      @(negedge clk);
      we0 = we_cnt;
      resp0 = resp_cnt;
      rq.req_valid = 1'b1;
      rq.req_we = 1'b1;
      rq.req_size = 2'd0;
      rq.req_addr = 32'h31;
      rq.req_wdata = 32'h77;
      @(negedge clk);
      rq.req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rmwrst_ready", 32'(rq.req_ready), 32'd1);
      chk("rmwrst_rdata", rq.resp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      chk("rmwrst_no_we", 32'(we_cnt - we0), 32'd0);
      chk("rmwrst_no_resp", 32'(resp_cnt - resp0), 32'd0);

      // Three loads with req_valid held high.
      model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mrd, mer, mlat, mnre, mnwe);
      a0 = acc_cnt;
      nrdy = 0;
      nresp = 0;
      rq.req_valid = 1'b1;
      rq.req_we = 1'b0;
      rq.req_size = 2'd2;
      rq.req_unsigned = 1'b0;
      rq.req_addr = 32'h10;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (acc_cnt - a0 >= 3) rq.req_valid = 1'b0;
         if (!rq.req_ready) nrdy++;
         if (rq.resp_valid) begin
            if (nresp < 3) rt[nresp] = cyc;
            chk($sformatf("b2b_rdata%0d", nresp), rq.resp_rdata, mrd);
            nresp++;
         end
      end
      rq.req_valid = 1'b0;
      chk("b2b_nresp", 32'(nresp), 32'd3);
      chk("b2b_busy_cycles", 32'(nrdy), 32'd6);
      if (nresp >= 3) begin
         chk("b2b_gap1", 32'(rt[1] - rt[0]), 32'd3);
         chk("b2b_gap2", 32'(rt[2] - rt[1]), 32'd3);
      end

      for (int t = 0; t < 250; t++) begin
         logic        rwe;
         logic [1:0]  rsz;
         logic        runs;
         logic [31:0] raddr;
         logic [31:0] rwd;
         rwe = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 3));
         runs = 1'($urandom_range(0, 1));
         raddr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0)
            raddr = raddr | (32'h1 << $urandom_range(10, 31));
         rwd = $urandom;
         do_req(rwe, rsz, runs, raddr, rwd, rd, er, lat, nre, nwe);
         model(rwe, rsz, runs, raddr, rwd, mrd, mer, mlat, mnre, mnwe);
         nm = $sformatf("rnd%0d", t);
         chk({nm, "_rdata"}, rd, mrd);
         chk({nm, "_err"}, 32'(er), 32'(mer));
         chk({nm, "_lat"}, 32'(lat), 32'(mlat));
         chk({nm, "_acc"}, 32'(nre * 2 + nwe), 32'(mnre * 2 + mnwe));
         if (($urandom_range(0, 3) == 0)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      diffs = 0;
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < 4; j++)
            if (mem_arr[i][8*j +: 8] !== ref_b[4*i + j]) diffs++;
      chk("mem_image_diffs", 32'(diffs), 32'd0);
      chk("we_re_overlap", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
